seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Shares one combinational hex-to-7-segment decoder between all digits.
  - Presents one 4-bit nibble at a time on dec_din.
  - Registers the returned segment pattern.
  - Drives active-low digit enables, with a dead-time blank between digits to suppress ghosting.
- Sits between the system's value registers and the board's display pins.
- Display data is double-buffered and only changes at frame boundaries.

---
 rtl/seg7_scan_if.sv | 27 ++
 rtl/seg7_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Bus between the system/board side and the 7-segment scan controller.
// Carries the display load path, the shared-decoder round trip and the
// display pins. The controller connects through the slave modport.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              dec_din;
  logic [6:0]              dec_dout;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output en, load, data, dp_in, dec_dout,
    input  dec_din, seg, dp, an, frame_done
  );

  modport slave (
    input  en, load, data, dp_in, dec_dout,
    output dec_din, seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display. One external combinational hex decoder is shared by all digits:
// the controller presents the current digit's nibble on dec_din and
// registers dec_dout during the BLANK gap, so the pattern is settled before
// the digit is lit. Display data is double-buffered (staging -> shadow) and
// the shadow only changes at frame boundaries or while idle.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zeros).
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int DEAD       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_scan_if.slave   bus
);

  localparam int MAXC = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Scan state and registered display outputs
  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [CW-1:0]           r_cnt;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  // Double buffer: staging collects loads, shadow feeds the display
  logic [4*NUM_DIGITS-1:0] r_stg_data;
  logic [NUM_DIGITS-1:0]   r_stg_dp;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_shd_data;
  logic [NUM_DIGITS-1:0]   r_shd_dp;

  logic [CW-1:0]           w_cnt_inc;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_an_show;
  logic [6:0]              w_seg_next;
  logic                    w_dp_next;
  logic                    w_commit;

  assign w_cnt_inc = r_cnt + CW'(1);

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_zero_run;

  // Digit k (k>0) is a leading zero when it and every higher digit are zero
  // with no decimal point; scan from the top digit down.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned (otherwise a latch is inferred); blocking '=' is right
    // here because w_zero_run carries a value from one iteration to the next.
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero_run = w_zero_run && (r_shd_data[4*k +: 4] == 4'h0) && !r_shd_dp[k];
      w_lz[k]    = w_zero_run;
    end
  end

  assign w_blank = w_lz[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  // What the current digit should look like once its SHOW slot starts
  assign w_an_show  = w_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
  assign w_seg_next = w_blank ? 7'h00 : bus.dec_dout;
  assign w_dp_next  = w_blank ? 1'b0 : r_shd_dp[r_idx];

  // Shadow may be refreshed at the end of a frame or at any time while idle,
  // so the first frame after enabling already shows fresh data.
  assign w_commit = r_frame_done || (r_state == IDLE);

  // Scan FSM: BLANK (load seg) -> SHOW (light digit) per digit, outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_an         <= '1;
      r_seg        <= '0;
      r_dp         <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (!bus.en) begin
      // NOTE: state registers use non-blocking '<=' so every flop samples the
      // pre-edge values of the others, matching real hardware.
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_an         <= '1;
      r_seg        <= '0;
      r_dp         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state      <= BLANK;
          r_idx        <= '0;
          r_cnt        <= '0;
          r_an         <= '1;
          r_frame_done <= 1'b0;
        end
        BLANK: begin
          r_seg <= w_seg_next;
          r_dp  <= w_dp_next;
          if (r_cnt == DEAD_LAST) begin
            r_state      <= SHOW;
            r_cnt        <= '0;
            r_an         <= w_an_show;
            r_frame_done <= (r_idx == IDX_LAST) && (DIV_LAST == '0);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        SHOW: begin
          if (r_cnt == DIV_LAST) begin
            r_state      <= BLANK;
            r_cnt        <= '0;
            r_an         <= '1;
            r_frame_done <= 1'b0;
            r_idx        <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
          end else begin
            r_cnt        <= w_cnt_inc;
            r_frame_done <= (r_idx == IDX_LAST) && (w_cnt_inc == DIV_LAST);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Load path: capture into staging, move to shadow at frame end / when idle;
  // a load on a commit cycle goes straight to shadow and drops any pending one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffers are plain registers, not a RAM, so they are reset
      // to guarantee a "0" display after reset rather than random segments.
      r_stg_data <= '0;
      r_stg_dp   <= '0;
      r_pending  <= 1'b0;
      r_shd_data <= '0;
      r_shd_dp   <= '0;
    end else if (w_commit) begin
      if (bus.load) begin
        r_shd_data <= bus.data;
        r_shd_dp   <= bus.dp_in;
      end else if (r_pending) begin
        r_shd_data <= r_stg_data;
        r_shd_dp   <= r_stg_dp;
      end
      r_pending <= 1'b0;
    end else if (bus.load) begin
      r_stg_data <= bus.data;
      r_stg_dp   <= bus.dp_in;
      r_pending  <= 1'b1;
    end
  end

  assign bus.dec_din    = r_shd_data[{r_idx, 2'b00} +: 4];
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with NUM_DIGITS=4, DIV=4, DEAD=1.
// A frame-time model predicts an/seg/dp/frame_done every cycle from the
// scan schedule (slot = DEAD+DIV cycles, frame = 4 slots); directed steps
// add literal checks for the key display patterns.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIV   = 4;
  localparam int DEAD  = 1;
  localparam int SLOT  = DEAD + DIV;
  localparam int FRAME = ND * SLOT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Board-side hex to 7-segment decoder, bit6=a ... bit0=g
  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  assign bus.dec_dout = seg_lut(bus.dec_din);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, wanted %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_run = 1'b0;       // scanning (not idle)
  int        m_t   = 0;          // cycles since the first BLANK of this run
  logic [15:0] m_shd = '0, m_stg = '0;
  logic [3:0]  m_shd_dp = '0, m_stg_dp = '0;
  bit        m_pend = 1'b0;

  function automatic bit lz_blank(input int d);
    bit z;
    z = (d > 0);
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 0; k < ND; k++)
      if (k >= d && (m_shd[4*k +: 4] != 4'h0 || m_shd_dp[k])) z = 1'b0;
`else
    z = 1'b0;
`endif
    return z;
  endfunction

  // Advance the model one clock using the inputs seen at the edge
  always @(posedge clk or negedge rst_n) begin : model
    bit fd_now;
    if (!rst_n) begin
      m_run <= 1'b0; m_t <= 0;
      m_shd <= '0; m_shd_dp <= '0; m_stg <= '0; m_stg_dp <= '0; m_pend <= 1'b0;
    end else begin
      fd_now = m_run && ((m_t % FRAME) == FRAME - 1);
      if (fd_now || !m_run) begin
        if (bus.load) begin
          m_shd <= bus.data; m_shd_dp <= bus.dp_in;
        end else if (m_pend) begin
          m_shd <= m_stg; m_shd_dp <= m_stg_dp;
        end
        m_pend <= 1'b0;
      end else if (bus.load) begin
        m_stg <= bus.data; m_stg_dp <= bus.dp_in; m_pend <= 1'b1;
      end
      if (!bus.en)     m_run <= 1'b0;
      else if (!m_run) begin m_run <= 1'b1; m_t <= 0; end
      else             m_t <= m_t + 1;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin : cmp
    int pos, d, ph;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    bit seg_valid, bl;
    e_an = '1; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0; seg_valid = 1'b1;
    if (m_run) begin
      pos = m_t % FRAME;
      d   = pos / SLOT;
      ph  = pos % SLOT;
      bl  = lz_blank(d);
      e_fd = (d == ND - 1) && (ph == SLOT - 1);
      if (ph < DEAD) begin
        seg_valid = 1'b0;
      end else begin
        e_an  = bl ? 4'hF : ~(4'(1) << d);
        e_seg = bl ? 7'h00 : seg_lut(m_shd[4*d +: 4]);
        e_dp  = m_shd_dp[d];
      end
    end
    check("model_an", bus.an, e_an);
    check("model_frame_done", bus.frame_done, e_fd);
    if (seg_valid) begin
      check("model_seg", bus.seg, e_seg);
      check("model_dp", bus.dp, e_dp);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_an(input logic [3:0] tgt, input string name);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.an == tgt) break;
    end
    check(name, bus.an, tgt);
  endtask

  task automatic wait_fd(input string name);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.frame_done) break;
    end
    check(name, bus.frame_done, 1'b1);
  endtask

  task automatic load_now(input logic [15:0] d, input logic [3:0] p);
    bus.load = 1'b1; bus.data = d; bus.dp_in = p;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    bus.en = 1'b0; bus.load = 1'b0; bus.data = '0; bus.dp_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an", bus.an, 4'hF);
    check("rst_seg", bus.seg, 7'h00);
    check("rst_dp", bus.dp, 1'b0);
    check("rst_fd", bus.frame_done, 1'b0);

    // Enable with no load: digits show "0", frame period 20
    rst_n = 1'b1; bus.en = 1'b1;
    wait_an(4'b1110, "first_d0");
    check("first_d0_seg", bus.seg, 7'b1111110);
    wait_fd("fd_a");
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.frame_done && n < 100);
    check("frame_period", n, FRAME);

    // Mid-frame load is held until the frame ends
    wait_an(4'b1101, "ld_slot");
    load_now(16'h12AF, 4'b0100);
    wait_an(4'b1011, "old_d2");
    check("old_d2_seg", bus.seg, 7'b1111110);
    check("old_d2_dp", bus.dp, 1'b0);
    wait_fd("fd_b");
    wait_an(4'b1110, "new_d0");
    check("new_d0_seg_F", bus.seg, 7'b1000111);
    wait_an(4'b1101, "new_d1");
    check("new_d1_seg_A", bus.seg, 7'b1110111);
    wait_an(4'b1011, "new_d2");
    check("new_d2_seg_2", bus.seg, 7'b1101101);
    check("new_d2_dp", bus.dp, 1'b1);
    wait_an(4'b0111, "new_d3");
    check("new_d3_seg_1", bus.seg, 7'b0110000);
    check("new_d3_dp", bus.dp, 1'b0);

    // Pending load overridden by a load on the frame_done cycle
    wait_an(4'b1101, "pend_slot");
    load_now(16'h3333, 4'b0000);
    wait_fd("fd_c");
    load_now(16'h0005, 4'b0000);
    wait_an(4'b1110, "byp_d0");
    check("byp_d0_seg_5", bus.seg, 7'b1011011);
    wait_an(4'b1101, "byp_d1");
    check("byp_d1_seg_0", bus.seg, 7'b1111110);
    wait_fd("fd_d");
    wait_an(4'b1110, "after_d0");
    check("after_d0_seg_5", bus.seg, 7'b1011011);
    wait_an(4'b1101, "after_d1");
    check("after_d1_seg_0", bus.seg, 7'b1111110);

    // en dropped during digit 2, then re-enabled
    wait_an(4'b1011, "en_slot");
    bus.en = 1'b0;
    @(negedge clk);
    check("en_off_an", bus.an, 4'hF);
    check("en_off_seg", bus.seg, 7'h00);
    check("en_off_fd", bus.frame_done, 1'b0);
    bus.en = 1'b1;
    @(negedge clk);
    check("en_blank_an", bus.an, 4'hF);
    @(negedge clk);
    check("en_restart_an", bus.an, 4'b1110);
    check("en_restart_seg", bus.seg, 7'b1011011);

    // Asynchronous reset in the middle of a SHOW slot
    wait_an(4'b1101, "rst_slot");
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", bus.an, 4'hF);
    check("arst_seg", bus.seg, 7'h00);
    check("arst_fd", bus.frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_an(4'b1110, "post_rst_d0");
    check("post_rst_seg_0", bus.seg, 7'b1111110);
    check("post_rst_dp", bus.dp, 1'b0);

`ifdef LEADING_ZERO_BLANK_EN
    // Leading zeros: digits 3 and 2 of 0x0070 are dark, digit 1 shows 7
    load_now(16'h0070, 4'b0000);
    wait_fd("fd_lz1");
    wait_an(4'b1101, "lz_d1");
    check("lz_d1_seg_7", bus.seg, 7'b1110000);
    repeat (SLOT) @(negedge clk);
    check("lz_d2_an", bus.an, 4'hF);
    repeat (SLOT) @(negedge clk);
    check("lz_d3_an", bus.an, 4'hF);
    check("lz_d3_seg", bus.seg, 7'h00);
    load_now(16'h0000, 4'b0000);
    wait_fd("fd_lz2");
    wait_an(4'b1110, "lz0_d0");
    check("lz0_d0_seg", bus.seg, 7'b1111110);
    repeat (SLOT) @(negedge clk);
    check("lz0_d1_an", bus.an, 4'hF);
`endif

    repeat (2 * FRAME) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
